imu_spi_seq: RTL and testbench

//  Command sequencer directly upstream of the SPI monarch. It drives wrt/cmd into the

---
 rtl/imu_spi_pkg.sv | 38 +++
 rtl/imu_spi_seq_sync2.sv | 30 +++
 rtl/imu_spi_seq.sv | 139 +++++++++++++
 tb/tb_imu_spi_seq.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/imu_spi_pkg.sv
// ---------------------------------------------------------------------------
// imu_spi_pkg
// Shared types and constants for the IMU command sequencer:
//   state_t        sequencer FSM state encoding
//   CFG*_DEF       default sensor configuration writes
//   YAWL_RD/YAWH_RD  read commands for the yaw-rate low/high bytes
//   mk_rd()        builds a read command {R=1, addr[6:0], 8'h00}
// ---------------------------------------------------------------------------
package imu_spi_pkg;

  typedef enum logic [3:0] {
    PWR_WAIT = 4'd0,
    CFG0_S   = 4'd1,
    CFG0_W   = 4'd2,
    CFG1_S   = 4'd3,
    CFG1_W   = 4'd4,
    CFG2_S   = 4'd5,
    CFG2_W   = 4'd6,
    IDLE     = 4'd7,
    RDL_S    = 4'd8,
    RDL_W    = 4'd9,
    RDH_S    = 4'd10,
    RDH_W    = 4'd11
  } state_t;

  localparam logic [15:0] CFG0_DEF = 16'h0D02;  // INT pin = data-ready
  localparam logic [15:0] CFG1_DEF = 16'h1160;  // gyro ODR 416 Hz
  localparam logic [15:0] CFG2_DEF = 16'h1440;  // rounding enabled

  localparam logic [15:0] YAWL_RD = 16'hA600;   // read 0x26, yaw low byte
  localparam logic [15:0] YAWH_RD = 16'hA700;   // read 0x27, yaw high byte

  // Read command for a 7-bit register address; data field is don't-care (zero).
  function automatic logic [15:0] mk_rd(input logic [6:0] addr);
    return {1'b1, addr, 8'h00};
  endfunction

endpackage

// File: rtl/imu_spi_seq_sync2.sv
// ---------------------------------------------------------------------------
// sync2
// Two-flop synchroniser for a single asynchronous level input.
// Ports:
//   clk  in  destination clock
//   rst  in  asynchronous reset, active high (both flops clear to 0)
//   i_d  in  asynchronous input
//   o_q  out synchronised output (two clk cycles of latency)
// ---------------------------------------------------------------------------
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;

  // Metastability filter: first flop may go metastable, second one resolves it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b0;
      o_q    <= 1'b0;
    end else begin
      r_meta <= i_d;
      o_q    <= r_meta;
    end
  end

endmodule

// File: rtl/imu_spi_seq.sv
// ---------------------------------------------------------------------------
// imu_spi_seq
// Command sequencer sitting in front of the SPI monarch. After reset it waits
// for the sensor to power up, writes three configuration registers, then
// reads the yaw-rate low/high bytes every time the sensor's INT line is seen
// high in IDLE, presenting the assembled 16-bit value with a 1-cycle vld.
// Ports:
//   clk      in   system clock, posedge
//   rst      in   asynchronous reset, active high
//   INT      in   sensor data-ready level, asynchronous to clk
//   done     in   monarch transaction complete (cleared when wrt is taken)
//   rd_data  in   monarch read data, byte in [7:0], valid while done=1
//   wrt      out  1-cycle pulse starting a monarch transaction
//   cmd      out  {R/W, addr[6:0], data[7:0]}, valid while wrt=1
//   yaw_rt   out  signed yaw rate {high, low}, holds between updates
//   vld      out  1-cycle pulse when yaw_rt updates
// ---------------------------------------------------------------------------
module imu_spi_seq
  import imu_spi_pkg::*;
#(
  parameter int          INIT_CNT_W = 16,
  parameter logic [15:0] CFG0       = CFG0_DEF,
  parameter logic [15:0] CFG1       = CFG1_DEF,
  parameter logic [15:0] CFG2       = CFG2_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        INT,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic        wrt,
  output logic [15:0] cmd,
  output logic [15:0] yaw_rt,
  output logic        vld
);

  state_t                r_state;
  logic [INIT_CNT_W-1:0] r_timer;
  logic [7:0]            r_low;
  logic                  w_int_s;

  sync2 u_int_sync (
    .clk (clk),
    .rst (rst),
    .i_d (INT),
    .o_q (w_int_s)
  );

  // Sequencer FSM with power-up timer and registered outputs. wrt is raised on
  // the edge that enters a *_S state, so it is high for exactly the one cycle
  // spent in that state, and cmd is loaded on that same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= PWR_WAIT;
      r_timer <= '0;
      r_low   <= 8'h00;
      wrt     <= 1'b0;
      cmd     <= 16'h0000;
      yaw_rt  <= 16'h0000;
      vld     <= 1'b0;
    end else begin
      wrt <= 1'b0;
      vld <= 1'b0;
      case (r_state)
        PWR_WAIT: begin
          // Counter saturates: once all ones we leave and it is never touched again.
          if (&r_timer) begin
            r_state <= CFG0_S;
            wrt     <= 1'b1;
            cmd     <= CFG0;
          end else begin
            r_timer <= r_timer + {{(INIT_CNT_W-1){1'b0}}, 1'b1};
          end
        end
        CFG0_S: r_state <= CFG0_W;
        CFG0_W: begin
          if (done) begin
            r_state <= CFG1_S;
            wrt     <= 1'b1;
            cmd     <= CFG1;
          end else begin
            r_state <= CFG0_W;
          end
        end
        CFG1_S: r_state <= CFG1_W;
        CFG1_W: begin
          if (done) begin
            r_state <= CFG2_S;
            wrt     <= 1'b1;
            cmd     <= CFG2;
          end else begin
            r_state <= CFG1_W;
          end
        end
        CFG2_S: r_state <= CFG2_W;
        CFG2_W: begin
          if (done) begin
            r_state <= IDLE;
          end else begin
            r_state <= CFG2_W;
          end
        end
        IDLE: begin
          // Level-sensitive: a still-high INT starts the next pair immediately.
          if (w_int_s) begin
            r_state <= RDL_S;
            wrt     <= 1'b1;
            cmd     <= YAWL_RD;
          end else begin
            r_state <= IDLE;
          end
        end
        RDL_S: r_state <= RDL_W;
        RDL_W: begin
          if (done) begin
            r_low   <= rd_data[7:0];
            r_state <= RDH_S;
            wrt     <= 1'b1;
            cmd     <= YAWH_RD;
          end else begin
            r_state <= RDL_W;
          end
        end
        RDH_S: r_state <= RDH_W;
        RDH_W: begin
          if (done) begin
            yaw_rt  <= {rd_data[7:0], r_low};
            vld     <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_state <= RDH_W;
          end
        end
        default: r_state <= PWR_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_imu_spi_seq.sv
// ---------------------------------------------------------------------------
// tb_imu_spi_seq
// Directed bench for imu_spi_seq with a small SPI monarch + sensor model.
// A transaction-level reference tracks the expected command stream (three
// config writes, then alternating yaw-L/yaw-H reads) and the expected yaw
// value/vld timing, and is compared against the DUT on every cycle.
// ---------------------------------------------------------------------------
module tb_imu_spi_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        INT = 1'b0;
  logic        done;
  logic [15:0] rd_data;
  logic        wrt;
  logic [15:0] cmd;
  logic [15:0] yaw_rt;
  logic        vld;

  always #5 clk = ~clk;

  imu_spi_seq #(.INIT_CNT_W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .INT     (INT),
    .done    (done),
    .rd_data (rd_data),
    .wrt     (wrt),
    .cmd     (cmd),
    .yaw_rt  (yaw_rt),
    .vld     (vld)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // ---------------- SPI monarch + sensor model ----------------
  localparam int XFER = 16;
  logic        m_busy;
  int          m_cnt;
  logic [15:0] m_cmd;
  logic [7:0]  cfg_reg [0:127];
  logic [7:0]  yaw_l = 8'h00;
  logic [7:0]  yaw_h = 8'h00;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy  <= 1'b0;
      done    <= 1'b0;
      rd_data <= 16'h0000;
      m_cnt   <= 0;
      m_cmd   <= 16'h0000;
    end else if (m_busy) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        m_busy <= 1'b0;
        done   <= 1'b1;
        if (m_cmd[15]) begin
          if (m_cmd[14:8] == 7'h26)      rd_data <= {8'h00, yaw_l};
          else if (m_cmd[14:8] == 7'h27) rd_data <= {8'h00, yaw_h};
          else                           rd_data <= {8'h00, cfg_reg[m_cmd[14:8]]};
        end else begin
          cfg_reg[m_cmd[14:8]] <= m_cmd[7:0];
          rd_data <= 16'h0000;
        end
      end
    end else if (wrt) begin
      m_busy <= 1'b1;
      done   <= 1'b0;
      m_cnt  <= XFER;
      m_cmd  <= cmd;
    end
  end

  // ---------------- Reference model + per-cycle compare ----------------
  logic [15:0] cfg_exp [0:2];
  logic [15:0] cmd_log [$];
  int          wrt_cnt, vld_cnt, first_wrt_cyc, cfg_done_cyc, rd4_cyc;
  int          m_idx;
  bit          m_phase, m_pend, arm_vld, prev_done;
  logic [7:0]  m_l;
  logic [15:0] m_next, m_yaw, exp_cmd;

  initial begin
    cfg_exp[0] = 16'h0D02;
    cfg_exp[1] = 16'h1160;
    cfg_exp[2] = 16'h1440;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk(wrt == 1'b0, "rst_wrt", {31'd0, wrt}, 32'd0);
        chk(vld == 1'b0, "rst_vld", {31'd0, vld}, 32'd0);
        chk(yaw_rt == 16'h0000, "rst_yaw", {16'd0, yaw_rt}, 32'd0);
        m_idx = 0; m_phase = 1'b0; m_pend = 1'b0; arm_vld = 1'b0; prev_done = 1'b0;
        m_yaw = 16'h0000; m_next = 16'h0000; m_l = 8'h00;
        wrt_cnt = 0; vld_cnt = 0; first_wrt_cyc = 0; cfg_done_cyc = 0; rd4_cyc = 0;
        cmd_log.delete();
      end else begin
        if (wrt) begin
          chk(!m_busy, "wrt_while_busy", {31'd0, m_busy}, 32'd0);
          if (m_idx < 3) begin
            exp_cmd = cfg_exp[m_idx];
            m_idx++;
          end else begin
            // read command: {R=1, addr, 8'h00}; low byte at 0x26, high at 0x27
            exp_cmd = {1'b1, (m_phase ? 7'h27 : 7'h26), 8'h00};
            if (!m_phase) m_l = yaw_l;
            else begin
              m_pend = 1'b1;
              m_next = {yaw_h, m_l};
            end
            m_phase = ~m_phase;
          end
          chk(cmd == exp_cmd, "cmd_seq", {16'd0, cmd}, {16'd0, exp_cmd});
          if (wrt_cnt == 0) first_wrt_cyc = cyc;
          cmd_log.push_back(cmd);
          wrt_cnt++;
          if (wrt_cnt == 4) rd4_cyc = cyc;
        end
        chk(vld == arm_vld, "vld_timing", {31'd0, vld}, {31'd0, arm_vld});
        if (vld) begin
          chk(m_pend, "vld_unexpected", 32'd1, {31'd0, m_pend});
          chk(yaw_rt == m_next, "yaw_value", {16'd0, yaw_rt}, {16'd0, m_next});
          m_yaw  = m_next;
          m_pend = 1'b0;
          vld_cnt++;
        end else begin
          chk(yaw_rt == m_yaw, "yaw_hold", {16'd0, yaw_rt}, {16'd0, m_yaw});
        end
        if (done && !prev_done && wrt_cnt == 3 && m_idx == 3) cfg_done_cyc = cyc;
        arm_vld   = m_pend && done && !prev_done;
        prev_done = done;
      end
    end
  end

  // ---------------- Directed stimulus ----------------
  int rel_cyc;

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    rel_cyc = cyc;
  endtask

  task automatic wait_vld(input int n, input int budget, input string nm);
    int k = 0;
    while (vld_cnt < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    chk(vld_cnt >= n, nm, vld_cnt, n);
  endtask

  task automatic wait_wrt(input int n, input int budget, input string nm);
    int k = 0;
    while (wrt_cnt < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    chk(wrt_cnt >= n, nm, wrt_cnt, n);
  endtask

  task automatic pulse_int();
    @(posedge clk); #3;
    INT = 1'b1;
    repeat (4) @(posedge clk); #3;
    INT = 1'b0;
  endtask

  initial begin
    int k;
    // 1: power-up wait then exactly three config writes
    do_reset();
    repeat (450) @(posedge clk);
    @(negedge clk); #1;
    chk(wrt_cnt == 3, "init_wrt_count", wrt_cnt, 3);
    chk(cmd_log.size() > 2 && cmd_log[0] == 16'h0D02, "init_cmd0", (cmd_log.size() > 0) ? cmd_log[0] : 16'hxxxx, 16'h0D02);
    chk(cmd_log.size() > 2 && cmd_log[1] == 16'h1160, "init_cmd1", (cmd_log.size() > 1) ? cmd_log[1] : 16'hxxxx, 16'h1160);
    chk(cmd_log.size() > 2 && cmd_log[2] == 16'h1440, "init_cmd2", (cmd_log.size() > 2) ? cmd_log[2] : 16'hxxxx, 16'h1440);
    chk((first_wrt_cyc - rel_cyc) inside {[255:256]}, "first_wrt_delay", first_wrt_cyc - rel_cyc, 255);
    chk(cfg_reg[7'h0D] == 8'h02, "sensor_reg0D", {24'd0, cfg_reg[7'h0D]}, 32'h02);
    chk(cfg_reg[7'h11] == 8'h60, "sensor_reg11", {24'd0, cfg_reg[7'h11]}, 32'h60);
    chk(cfg_reg[7'h14] == 8'h40, "sensor_reg14", {24'd0, cfg_reg[7'h14]}, 32'h40);

    // 2: single read pair, 0x1234
    yaw_l = 8'h34; yaw_h = 8'h12;
    pulse_int();
    wait_vld(1, 300, "vld1_timeout");
    repeat (60) @(posedge clk);
    @(negedge clk); #1;
    chk(yaw_rt == 16'h1234, "yaw_1234", {16'd0, yaw_rt}, 32'h1234);
    chk(vld_cnt == 1, "one_vld", vld_cnt, 1);
    chk(wrt_cnt == 5, "pair_wrt_count", wrt_cnt, 5);
    chk(cmd_log.size() == 5 && cmd_log[3] == 16'hA600 && cmd_log[4] == 16'hA700, "read_cmds",
        (cmd_log.size() > 4) ? {cmd_log[3], cmd_log[4]} : 32'hxxxxxxxx, 32'hA600A700);

    // 3: negative value, then hold
    yaw_l = 8'hFE; yaw_h = 8'hFF;
    pulse_int();
    wait_vld(2, 300, "vld2_timeout");
    @(negedge clk); #1;
    chk(yaw_rt == 16'hFFFE, "yaw_minus2", {16'd0, yaw_rt}, 32'hFFFE);
    repeat (100) @(posedge clk);
    @(negedge clk); #1;
    chk(yaw_rt == 16'hFFFE && vld_cnt == 2, "yaw_hold_long", {16'd0, yaw_rt}, 32'hFFFE);

    // 4: INT held high -> back-to-back pairs
    yaw_l = 8'h5A; yaw_h = 8'hA5;
    @(posedge clk); #3;
    INT = 1'b1;
    wait_vld(6, 600, "b2b_timeout");
    #3 INT = 1'b0;
    repeat (150) @(posedge clk);
    @(negedge clk); #1;
    chk(wrt_cnt - 3 == 2 * vld_cnt, "b2b_pairs", wrt_cnt - 3, 2 * vld_cnt);
    chk(yaw_rt == 16'hA55A, "yaw_a55a", {16'd0, yaw_rt}, 32'hA55A);

    // 5: async reset while waiting on the high-byte read
    @(posedge clk); #3;
    INT = 1'b1;
    k = 0;
    while (!(wrt && cmd == 16'hA700) && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk(k < 300, "rdh_timeout", k, 300);
    repeat (5) @(posedge clk);
    #2;
    chk(yaw_rt == 16'hA55A, "pre_rst_yaw", {16'd0, yaw_rt}, 32'hA55A);
    rst = 1'b1;
    #1;
    chk(wrt == 1'b0 && vld == 1'b0 && yaw_rt == 16'h0000, "async_rst",
        {15'd0, wrt, vld, yaw_rt}, 32'd0);
    INT = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    rel_cyc = cyc;
    repeat (450) @(posedge clk);
    @(negedge clk); #1;
    chk(wrt_cnt == 3, "reinit_wrt_count", wrt_cnt, 3);
    chk((first_wrt_cyc - rel_cyc) inside {[255:256]}, "reinit_delay", first_wrt_cyc - rel_cyc, 255);

    // 6: INT raised during CFG1 wait -> serviced only after init completes
    do_reset();
    wait_wrt(2, 400, "cfg1_timeout");
    repeat (3) @(posedge clk); #3;
    INT = 1'b1;
    wait_wrt(4, 300, "early_int_timeout");
    @(negedge clk); #1;
    chk(cmd_log.size() >= 4 && cmd_log[3] == 16'hA600, "read_after_cfg",
        (cmd_log.size() > 3) ? cmd_log[3] : 16'hxxxx, 16'hA600);
    chk(cfg_done_cyc > 0 && (rd4_cyc - cfg_done_cyc - 1) inside {[1:3]}, "idle_to_read",
        rd4_cyc - cfg_done_cyc - 1, 1);
    wait_vld(1, 300, "early_int_vld");
    #3 INT = 1'b0;
    repeat (150) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
